// File: rtl/reg_file_sb.sv
// reg_file_sb: multi-ported register file with a per-register busy scoreboard
// and an optional write-to-read bypass, used by the decode stage.
//
// Ports (port k occupies slice [k*W +: W] of each flattened bus):
//   i_clk, i_rst_n   clock (posedge), asynchronous active-low reset
//   i_rd_addr        read addresses, p_RD_PORTS x p_REG_ADDR_LEN
//   o_rd_data        combinational read data, p_RD_PORTS x p_WORD_LEN
//   o_rd_busy        combinational busy flag of each addressed register
//   i_wr_en          write enables, one per write port
//   i_wr_addr        write addresses, p_WR_PORTS x p_REG_ADDR_LEN
//   i_wr_data        write data, p_WR_PORTS x p_WORD_LEN
//   i_iss_en         issue strobe: mark i_iss_tgt busy
//   i_iss_tgt        register whose result is now in flight
//   o_busy_vec       registered busy bit per register
//   o_busy_cnt       registered number of busy registers
module reg_file_sb #(
  parameter int p_WORD_LEN      = 16,
  parameter int p_REG_ADDR_LEN  = 3,
  parameter int p_REG_FILE_SIZE = 8,
  parameter int p_RD_PORTS      = 2,
  parameter int p_WR_PORTS      = 2,
  parameter int p_BYPASS        = 1
) (
  input  logic                                 i_clk,
  input  logic                                 i_rst_n,
  input  logic [p_RD_PORTS*p_REG_ADDR_LEN-1:0] i_rd_addr,
  output logic [p_RD_PORTS*p_WORD_LEN-1:0]     o_rd_data,
  output logic [p_RD_PORTS-1:0]                o_rd_busy,
  input  logic [p_WR_PORTS-1:0]                i_wr_en,
  input  logic [p_WR_PORTS*p_REG_ADDR_LEN-1:0] i_wr_addr,
  input  logic [p_WR_PORTS*p_WORD_LEN-1:0]     i_wr_data,
  input  logic                                 i_iss_en,
  input  logic [p_REG_ADDR_LEN-1:0]            i_iss_tgt,
  output logic [p_REG_FILE_SIZE-1:0]           o_busy_vec,
  output logic [p_REG_ADDR_LEN:0]              o_busy_cnt
);

  localparam int AL = p_REG_ADDR_LEN;
  localparam int W  = p_WORD_LEN;
  localparam int CW = p_REG_ADDR_LEN + 1;

  logic [W-1:0]               regs_q [p_REG_FILE_SIZE];
  logic [W-1:0]               wr_val [p_REG_FILE_SIZE];
  logic [p_REG_FILE_SIZE-1:0] wr_hit;
  logic [p_REG_FILE_SIZE-1:0] busy_q;
  logic [p_REG_FILE_SIZE-1:0] busy_nxt;
  logic [CW-1:0]              cnt_q;
  logic [CW-1:0]              cnt_nxt;
  logic [CW-1:0]              inc;
  logic [CW-1:0]              dec;

  // Per-register write resolution. Ports are scanned in ascending order so
  // the highest-index enabled port to an address is the one that sticks.
  // Register 0 and out-of-range addresses never match. Gated by reset so a
  // pending write is neither stored nor forwarded while reset is held.
  always_comb begin : wr_resolve
    wr_hit = '0;
    for (int unsigned a = 0; a < p_REG_FILE_SIZE; a++) begin
      wr_val[a] = '0;
    end
    for (int unsigned a = 0; a < p_REG_FILE_SIZE; a++) begin
      for (int unsigned p = 0; p < p_WR_PORTS; p++) begin
        if (a != 0 && i_rst_n && i_wr_en[p] &&
            i_wr_addr[p*AL +: AL] == AL'(a)) begin
          wr_hit[a] = 1'b1;
          wr_val[a] = i_wr_data[p*W +: W];
        end
      end
    end
  end

  // Busy update: writeback clears, issue sets, and issue wins on a collision.
  // The count moves by the set/clear deltas so it tracks popcount(busy).
  always_comb begin : busy_next
    busy_nxt = '0;
    inc      = '0;
    dec      = '0;
    for (int unsigned a = 0; a < p_REG_FILE_SIZE; a++) begin
      if (a != 0) begin
        busy_nxt[a] = (i_iss_en && i_iss_tgt == AL'(a)) ||
                      (busy_q[a] && !wr_hit[a]);
      end
      if (busy_nxt[a] && !busy_q[a]) inc = inc + CW'(1);
      if (!busy_nxt[a] && busy_q[a]) dec = dec + CW'(1);
    end
    cnt_nxt = cnt_q + inc - dec;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin : state_q
    if (!i_rst_n) begin
      for (int unsigned a = 0; a < p_REG_FILE_SIZE; a++) begin
        regs_q[a] <= '0;
      end
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      for (int unsigned a = 0; a < p_REG_FILE_SIZE; a++) begin
        if (wr_hit[a]) regs_q[a] <= wr_val[a];
      end
      busy_q <= busy_nxt;
      cnt_q  <= cnt_nxt;
    end
  end

  // Read mux. Address 0 and out-of-range addresses match no register and
  // fall through to the zero default.
  always_comb begin : rd_mux
    o_rd_data = '0;
    o_rd_busy = '0;
    for (int unsigned k = 0; k < p_RD_PORTS; k++) begin
      for (int unsigned a = 0; a < p_REG_FILE_SIZE; a++) begin
        if (a != 0 && i_rd_addr[k*AL +: AL] == AL'(a)) begin
          if (p_BYPASS != 0 && wr_hit[a]) begin
            o_rd_data[k*W +: W] = wr_val[a];
            o_rd_busy[k]        = 1'b0;
          end else begin
            o_rd_data[k*W +: W] = regs_q[a];
            o_rd_busy[k]        = busy_q[a];
          end
        end
      end
    end
  end

  assign o_busy_vec = busy_q;
  assign o_busy_cnt = cnt_q;

endmodule

// File: tb/tb_reg_file_sb.sv
// tb_reg_file_sb: drives two reg_file_sb instances from the same inputs --
// "a" with default parameters (bypass on, 8 registers) and "b" with bypass
// off and only 6 registers, so addresses 6 and 7 are out of range for it.
// A behavioural model of the architectural state is checked every cycle,
// and directed scenarios pin the model with literal expectations.
module tb_reg_file_sb;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  wr_en;
  logic [2:0]  wr_addr [2];
  logic [15:0] wr_data [2];
  logic [2:0]  rd_addr [2];
  logic        iss_en;
  logic [2:0]  iss_tgt;

  logic [5:0]  rd_addr_bus;
  logic [5:0]  wr_addr_bus;
  logic [31:0] wr_data_bus;
  assign rd_addr_bus = {rd_addr[1], rd_addr[0]};
  assign wr_addr_bus = {wr_addr[1], wr_addr[0]};
  assign wr_data_bus = {wr_data[1], wr_data[0]};

  logic [31:0] rd_data_a, rd_data_b;
  logic [1:0]  rd_busy_a, rd_busy_b;
  logic [7:0]  bvec_a;
  logic [5:0]  bvec_b;
  logic [3:0]  cnt_a, cnt_b;

  int n_vec = 0;
  int n_err = 0;

  reg_file_sb dut_a (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_rd_addr(rd_addr_bus), .o_rd_data(rd_data_a), .o_rd_busy(rd_busy_a),
    .i_wr_en(wr_en), .i_wr_addr(wr_addr_bus), .i_wr_data(wr_data_bus),
    .i_iss_en(iss_en), .i_iss_tgt(iss_tgt),
    .o_busy_vec(bvec_a), .o_busy_cnt(cnt_a)
  );

  reg_file_sb #(.p_REG_FILE_SIZE(6), .p_BYPASS(0)) dut_b (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_rd_addr(rd_addr_bus), .o_rd_data(rd_data_b), .o_rd_busy(rd_busy_b),
    .i_wr_en(wr_en), .i_wr_addr(wr_addr_bus), .i_wr_data(wr_data_bus),
    .i_iss_en(iss_en), .i_iss_tgt(iss_tgt),
    .o_busy_vec(bvec_b), .o_busy_cnt(cnt_b)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // Architectural model: one array of register values and a busy set.
  // Instance b shares it; its out-of-range registers are simply never read.
  logic [15:0] m_reg [8];
  logic [7:0]  m_busy;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int a = 0; a < 8; a++) m_reg[a] <= '0;
      m_busy <= '0;
    end else begin
      for (int p = 0; p < 2; p++) begin
        if (wr_en[p]) begin
          if (wr_addr[p] != 0) m_reg[wr_addr[p]] <= wr_data[p];
          m_busy[wr_addr[p]] <= 1'b0;
        end
      end
      if (iss_en && iss_tgt != 0) m_busy[iss_tgt] <= 1'b1;
    end
  end

  function automatic void model_read(input int addr, input bit bypass, input int size,
                                     output logic [15:0] d, output logic b);
    d = '0;
    b = 1'b0;
    if (!rst_n || addr == 0 || addr >= size) return;
    d = m_reg[addr];
    b = m_busy[addr];
    if (bypass) begin
      for (int p = 0; p < 2; p++) begin
        if (wr_en[p] && int'(wr_addr[p]) == addr) begin
          d = wr_data[p];
          b = 1'b0;
        end
      end
    end
  endfunction

  always @(negedge clk) begin
    logic [15:0] d;
    logic        b;
    for (int k = 0; k < 2; k++) begin
      model_read(int'(rd_addr[k]), 1'b1, 8, d, b);
      chk("a_rd_data", 32'(rd_data_a[k*16 +: 16]), 32'(d));
      chk("a_rd_busy", 32'(rd_busy_a[k]), 32'(b));
      model_read(int'(rd_addr[k]), 1'b0, 6, d, b);
      chk("b_rd_data", 32'(rd_data_b[k*16 +: 16]), 32'(d));
      chk("b_rd_busy", 32'(rd_busy_b[k]), 32'(b));
    end
    chk("a_busy_vec", 32'(bvec_a), 32'(m_busy));
    chk("a_busy_cnt", 32'(cnt_a), $countones(m_busy));
    chk("b_busy_vec", 32'(bvec_b), 32'(m_busy[5:0]));
    chk("b_busy_cnt", 32'(cnt_b), $countones(m_busy[5:0]));
  end

  task automatic idle();
    wr_en  = '0;
    iss_en = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle();
    wr_addr[0] = '0; wr_addr[1] = '0;
    wr_data[0] = '0; wr_data[1] = '0;
    rd_addr[0] = '0; rd_addr[1] = '0;
    iss_tgt    = '0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    chk("lit_reset_cnt", 32'(cnt_a), 32'd0);
    chk("lit_reset_vec", 32'(bvec_a), 32'd0);

    // write + issue r3, then async reset between edges
    wr_en = 2'b01; wr_addr[0] = 3'd3; wr_data[0] = 16'h1234;
    iss_en = 1'b1; iss_tgt = 3'd3; rd_addr[0] = 3'd3;
    tick(); idle(); #1;
    chk("lit_r3_written", 32'(rd_data_a[15:0]), 32'h1234);
    chk("lit_r3_cnt", 32'(cnt_a), 32'd1);
    rst_n = 1'b0; #1;
    chk("lit_rst_r3", 32'(rd_data_a[15:0]), 32'h0);
    chk("lit_rst_cnt", 32'(cnt_a), 32'd0);
    wr_en = 2'b01; wr_addr[0] = 3'd3; wr_data[0] = 16'h9999;
    tick(); idle(); #1;
    rst_n = 1'b1;
    chk("lit_rst_held_r3", 32'(rd_data_a[15:0]), 32'h0);

    // same-edge write conflict on r5
    wr_en = 2'b11; wr_addr[0] = 3'd5; wr_addr[1] = 3'd5;
    wr_data[0] = 16'hAAAA; wr_data[1] = 16'h5555; rd_addr[0] = 3'd5; #1;
    chk("lit_conf_bypass", 32'(rd_data_a[15:0]), 32'h5555);
    chk("lit_conf_nb_old", 32'(rd_data_b[15:0]), 32'h0);
    tick(); idle(); #1;
    chk("lit_conf_a", 32'(rd_data_a[15:0]), 32'h5555);
    chk("lit_conf_b", 32'(rd_data_b[15:0]), 32'h5555);

    // r0 immutable
    wr_en = 2'b01; wr_addr[0] = 3'd0; wr_data[0] = 16'hFFFF;
    iss_en = 1'b1; iss_tgt = 3'd0; rd_addr[0] = 3'd0;
    tick(); idle(); #1;
    chk("lit_r0_data", 32'(rd_data_a[15:0]), 32'h0);
    chk("lit_r0_busy", 32'(bvec_a[0]), 32'd0);
    chk("lit_r0_cnt", 32'(cnt_a), 32'd0);

    // scoreboard: issue r2, r4, then write back r2
    iss_en = 1'b1; iss_tgt = 3'd2; tick();
    iss_tgt = 3'd4; tick(); idle(); rd_addr[1] = 3'd2; #1;
    chk("lit_sb_cnt2", 32'(cnt_a), 32'd2);
    chk("lit_sb_busy_r2", 32'(rd_busy_a[1]), 32'd1);
    wr_en = 2'b01; wr_addr[0] = 3'd2; wr_data[0] = 16'h0042; #1;
    chk("lit_sb_byp_busy", 32'(rd_busy_a[1]), 32'd0);
    chk("lit_sb_byp_data", 32'(rd_data_a[31:16]), 32'h0042);
    chk("lit_sb_nb_busy", 32'(rd_busy_b[1]), 32'd1);
    tick(); idle(); #1;
    chk("lit_sb_cnt1", 32'(cnt_a), 32'd1);

    // issue/writeback collision on r6 (out of range for instance b)
    iss_en = 1'b1; iss_tgt = 3'd6; tick(); #1;
    chk("lit_col_cnt_pre", 32'(cnt_a), 32'd2);
    wr_en = 2'b01; wr_addr[0] = 3'd6; wr_data[0] = 16'h0777;
    tick(); idle(); rd_addr[0] = 3'd6; #1;
    chk("lit_col_busy6", 32'(bvec_a[6]), 32'd1);
    chk("lit_col_cnt", 32'(cnt_a), 32'd2);
    chk("lit_col_data", 32'(rd_data_a[15:0]), 32'h0777);
    chk("lit_oor_data", 32'(rd_data_b[15:0]), 32'h0);
    chk("lit_oor_busy", 32'(rd_busy_b[0]), 32'd0);
    chk("lit_oor_cnt", 32'(cnt_b), 32'd1);

    // no-bypass build sees the old value during the write cycle
    wr_en = 2'b01; wr_addr[0] = 3'd1; wr_data[0] = 16'h0101; rd_addr[0] = 3'd1; #1;
    chk("lit_nb_old", 32'(rd_data_b[15:0]), 32'h0);
    chk("lit_byp_new", 32'(rd_data_a[15:0]), 32'h0101);
    tick(); idle(); #1;
    chk("lit_nb_new", 32'(rd_data_b[15:0]), 32'h0101);

    // randomized traffic, with occasional mid-cycle reset pulses
    for (int i = 0; i < 600; i++) begin
      wr_en = 2'($urandom);
      for (int p = 0; p < 2; p++) begin
        wr_addr[p] = 3'($urandom);
        wr_data[p] = 16'($urandom);
      end
      iss_en  = ($urandom_range(0, 2) != 0);
      iss_tgt = 3'($urandom);
      for (int k = 0; k < 2; k++) begin
        if ($urandom_range(0, 2) == 0) rd_addr[k] = wr_addr[k];
        else rd_addr[k] = 3'($urandom);
      end
      if ($urandom_range(0, 59) == 0) begin
        #1 rst_n = 1'b0;
        #1 rst_n = 1'b1;
      end
      tick();
    end
    idle();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/reg_file_sb.md
# reg_file_sb

Parametrised multi-ported register file with per-register busy scoreboard and optional write-to-read bypass, for the pipelined core's decode stage. Generalises the single-write, two-read file to p_RD_PORTS read ports and p_WR_PORTS write ports. Adds asynchronous reset of all registers. Tracks registers with an issued but not yet written-back result, so the hazard unit can stall on busy sources.

## Interface
- p_WORD_LEN, 16, data word width
- p_REG_ADDR_LEN, 3, register address width
- p_REG_FILE_SIZE, 8, number of registers (≤ 2^p_REG_ADDR_LEN); register 0 hardwired zero
- p_RD_PORTS, 2, number of asynchronous read ports (≥1)
- p_WR_PORTS, 2, number of synchronous write ports (≥1)
- p_BYPASS, 1, 1 = same-cycle write data forwarded to reads; 0 = reads see stored value only

Ports (port k occupies slice [k*W +: W] of each flattened bus):
- i_clk  in  1  clock, all state updates on posedge
- i_rst_n  in  1  reset, asynchronous, active-low
- i_rd_addr  in  p_RD_PORTS*p_REG_ADDR_LEN  read addresses
- o_rd_data  out  p_RD_PORTS*p_WORD_LEN  read data (combinational)
- o_rd_busy  out  p_RD_PORTS  busy flag of each addressed register (combinational)
- i_wr_en  in  p_WR_PORTS  write enables
- i_wr_addr  in  p_WR_PORTS*p_REG_ADDR_LEN  write addresses
- i_wr_data  in  p_WR_PORTS*p_WORD_LEN  write data
- i_iss_en  in  1  issue strobe: mark i_iss_tgt busy
- i_iss_tgt  in  p_REG_ADDR_LEN  register whose result is now in flight
- o_busy_vec  out  p_REG_FILE_SIZE  registered busy bit per register
- o_busy_cnt  out  p_REG_ADDR_LEN+1  registered count of busy registers

## Operation
- Storage: p_REG_FILE_SIZE words. reg[0] always reads 0; writes to address 0 are dropped; busy[0] never set.
- Reset (i_rst_n=0): all registers ← 0, busy_vec ← 0, busy_cnt ← 0, immediately (not clock-gated). While reset is held, writes and issues are ignored.
- Write: on posedge, each port with i_wr_en=1 and address ≠0 writes its data.
  - Two or more ports to the same address in one cycle: highest-index port wins; lower ports to that address are ignored.
- Writeback clears busy: any enabled write to address a clears busy[a].
- Issue: i_iss_en=1 with i_iss_tgt≠0 sets busy[i_iss_tgt].
  - Issue and write to the same register in the same cycle: issue wins and busy stays 1, because the new producer supersedes the one retiring. The write data is still stored.
  - Issue to an already-busy register: busy stays 1 (no count change).
- busy_cnt always equals popcount(busy_vec). It is updated in the same edge from the set/clear deltas and never wraps, since max = p_REG_FILE_SIZE-1.
- Read port k:
  - addr 0 → data 0, busy 0.
  - p_BYPASS=1: if any enabled write port targets addr this cycle, data = winning (highest-index) write data and busy = 0. Otherwise data = stored value and busy = busy_vec[addr].
  - p_BYPASS=0: data = stored value, busy = busy_vec[addr].
- Out-of-range address (≥ p_REG_FILE_SIZE): read returns 0 with busy 0; writes and issues to it are dropped.

## Timing
- Reads: zero latency, purely combinational from i_rd_addr, stored state and (bypass) write inputs.
- Writes/issues: take effect at the posedge they are sampled on; visible to non-bypass reads from the next cycle.
- o_busy_vec / o_busy_cnt: registered; reflect issues/writebacks one edge after sampling.
- Reset deassertion: first state update at the first posedge with i_rst_n=1.
- Reset asserted mid-cycle with writes pending: writes are lost, outputs drop to 0 asynchronously.

## Test plan
- Reset clears: write r3=0x1234, assert i_rst_n=0 between edges → o_rd_data for r3 = 0 immediately, o_busy_cnt=0.
- Write conflict: port0 wr r5=0xAAAA, port1 wr r5=0x5555 same edge → r5 reads 0x5555 next cycle; with p_BYPASS=1 it reads 0x5555 in the same cycle.
- r0 immutable: write r0=0xFFFF and issue r0 → read r0 = 0, busy_vec[0]=0, busy_cnt unchanged.
- Scoreboard: issue r2, then r4 → busy_cnt=2, o_rd_busy=1 for r2. Write r2=0x0042 → busy_cnt=1. Bypass read of r2 during the write cycle shows busy 0, data 0x0042.
- Issue/writeback collision: r6 busy; same edge issue r6 and write r6=0x0777 → busy[6] stays 1, count unchanged, r6 = 0x0777.
- p_BYPASS=0 build: write r1=0x0101 while reading r1 → old value in that cycle, 0x0101 next cycle.
